fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 201 ++++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: UART transmitter that pulls bytes from a show-ahead FIFO.
// Frames are 8N1 by default. Defining FIFO_UART_TX_PARITY_EN inserts an
// even-parity bit between the data bits and the stop bit.
// A new frame may begin on the last stop-bit cycle, so frames go out back to back.
module fifo_uart_tx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 CLOCK_50,
  input  logic                 RST_N,
  input  logic                 tx_enable,
  input  logic [DATA_BITS-1:0] fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // Even parity over the latched payload.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_e;
`endif

  state_e                 state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   rd_q, rd_d;
  logic                   busy_q, busy_d;
  logic                   launch_s;
  logic                   start_ok_s;
  logic                   baud_last_s;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  assign start_ok_s  = tx_enable & ~fifo_empty;
  assign baud_last_s = (baud_q == BAUD_LAST);

  // Next-state logic: bit timing, frame sequencing and the launch of a new frame.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + BAUD_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    launch_s = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (start_ok_s) begin
          launch_s = 1'b1;
        end else begin
          launch_s = 1'b0;
        end
      end
      START: begin
        if (baud_last_s) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          tx_d = 1'b0;
        end
      end
      DATA: begin
        if (baud_last_s) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end else begin
          tx_d = tx_q;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (baud_last_s) begin
          state_d = STOP;
          baud_d  = '0;
          tx_d    = 1'b1;
        end else begin
          tx_d = tx_q;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (baud_last_s) begin
          baud_d = '0;
          if (start_ok_s) begin
            launch_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          launch_s = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase

    // A launch latches the head word and drives the start bit on the next cycle.
    if (launch_s) begin
      state_d = START;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = fifo_data;
      tx_d    = 1'b0;
    end else begin
      shift_d = shift_d;
    end

    rd_d   = launch_s;
    busy_d = (state_d != IDLE);
  end

`ifdef FIFO_UART_TX_PARITY_EN
  // Parity of the word being sent is captured once at launch.
  always_comb begin
    parity_d = parity_q;
    if (launch_s) begin
      parity_d = even_parity(fifo_data);
    end else begin
      parity_d = parity_q;
    end
  end
`endif

  // State and output registers; the serial line idles high out of reset.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx        = tx_q;
  assign fifo_read = rd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench for fifo_uart_tx (CLKS_PER_BIT=4, DATA_BITS=8).
// The stimulus loads a FIFO model and queues the frames it expects. A serial
// monitor decodes tx, then pops the queue and compares each frame with it.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clk;
  logic       rst_n;
  logic       tx_enable;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_read;
  logic       tx;
  logic       busy;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int b2b_err = 0;

  fifo_uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB)) dut (
    .CLOCK_50  (clk),
    .RST_N     (rst_n),
    .tx_enable (tx_enable),
    .fifo_data (fifo_data),
    .fifo_empty(fifo_empty),
    .fifo_read (fifo_read),
    .tx        (tx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected tx bit sequence of a frame, index 0 = start bit.
  function automatic logic [15:0] frame_of(input logic [7:0] b);
    logic [15:0] f;
    f = 16'h0000;
    f[8:1] = b;
`ifdef FIFO_UART_TX_PARITY_EN
    f[9]  = ^b;
    f[10] = 1'b1;
`else
    f[9]  = 1'b1;
`endif
    return f;
  endfunction

  task automatic fifo_update();
    fifo_empty = (fq.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fq[0];
  endtask

  task automatic push(input logic [7:0] b, input bit expect_frame);
    fq.push_back(b);
    if (expect_frame) exp_q.push_back(b);
    fifo_update();
  endtask

  // One clock; the FIFO model pops whenever the DUT strobes fifo_read.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (fifo_read && fq.size() != 0) begin
        fq.delete(0);
        fifo_update();
      end
    end
  endtask

  task automatic wait_launch(input string name);
    for (int i = 0; i < 60 && !fifo_read; i++) step();
    chk(name, fifo_read, 1);
  endtask

  // fifo_read must never be high on two consecutive cycles.
  logic prev_rd = 1'b0;
  always @(negedge clk) begin
    if (fifo_read && prev_rd) b2b_err++;
    prev_rd = fifo_read;
  end

  // Serial monitor: each bit must hold for CPB cycles; the frame is compared at its last cycle.
  bit          mact = 1'b0;
  bit          mbad = 1'b0;
  int          mcnt = 0;
  logic [15:0] samp = 16'h0000;
  logic [7:0]  mexp;
  always @(negedge clk) begin
    if (!rst_n) begin
      mact = 1'b0;
    end else if (!mact) begin
      if (tx == 1'b0) begin
        mact = 1'b1;
        mcnt = 0;
        mbad = 1'b0;
        samp = 16'h0000;
        samp[0] = tx;
      end
    end else begin
      mcnt++;
      if (mcnt % CPB == 0) samp[mcnt / CPB] = tx;
      else if (tx !== samp[mcnt / CPB]) mbad = 1'b1;
      if (mcnt == FRAME - 1) begin
        mact = 1'b0;
        if (exp_q.size() == 0) begin
          chk("frame_unexpected", {16'd0, samp}, 32'd0);
        end else begin
          mexp = exp_q.pop_front();
          chk("frame", {15'd0, mbad, samp}, {16'd0, frame_of(mexp)});
        end
      end
    end
  end

  int bcnt, reads, falls;
  int rd_t[4];
  int bad;
  logic pbusy;

  initial begin
    rst_n = 1'b0;
    tx_enable = 1'b0;
    fifo_update();

    // Reset held, then idle with an empty FIFO.
    step(5);
    chk("reset_outputs", {29'd0, tx, busy, fifo_read}, 32'h4);
    rst_n = 1'b1;
    tx_enable = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_read !== 1'b0) bad++;
    end
    chk("idle_100_cycles", bad, 0);

    // Single byte 0x55.
    push(8'h55, 1'b1);
    bcnt = 0; reads = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (busy) bcnt++;
      if (fifo_read) reads++;
    end
    chk("single_busy_cycles", bcnt, FRAME);
    chk("single_reads", reads, 1);

    // Three bytes preloaded, sent back to back.
    tx_enable = 1'b0;
    push(8'hA3, 1'b1);
    push(8'h00, 1'b1);
    push(8'hFF, 1'b1);
    step();
    tx_enable = 1'b1;
    bcnt = 0; reads = 0; falls = 0; pbusy = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      step();
      if (busy) bcnt++;
      if (fifo_read) begin
        if (reads < 4) rd_t[reads] = i;
        reads++;
      end
      if (pbusy && !busy) falls++;
      pbusy = busy;
    end
    chk("burst_busy_cycles", bcnt, 3 * FRAME);
    chk("burst_reads", reads, 3);
    chk("burst_gap01", rd_t[1] - rd_t[0], FRAME);
    chk("burst_gap12", rd_t[2] - rd_t[1], FRAME);
    chk("burst_contiguous", falls, 1);

    // tx_enable dropped mid-frame: the frame completes, the next one waits.
    tx_enable = 1'b0;
    push(8'h0F, 1'b1);
    push(8'h3C, 1'b1);
    tx_enable = 1'b1;
    wait_launch("txen_launch");
    bcnt = 1; reads = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (i == 9) tx_enable = 1'b0;
      step();
      if (busy) bcnt++;
      if (fifo_read) reads++;
    end
    chk("txen_busy_cycles", bcnt, FRAME);
    chk("txen_no_pop", reads, 0);
    tx_enable = 1'b1;
    step();
    chk("txen_relaunch", {30'd0, busy, fifo_read}, 32'h3);
    step(FRAME + 5);

    // Reset in the middle of frame 0x81; 0xC3 must follow normally.
    push(8'h81, 1'b0);
    push(8'hC3, 1'b1);
    wait_launch("rst_launch");
    step(16);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {29'd0, tx, busy, fifo_read}, 32'h4);
    step(3);
    rst_n = 1'b1;
    bcnt = 0; reads = 0;
    for (int i = 0; i < FRAME + 20; i++) begin
      step();
      if (busy) bcnt++;
      if (fifo_read) reads++;
    end
    chk("post_rst_reads", reads, 1);
    chk("post_rst_busy_cycles", bcnt, FRAME);

    step(5);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("no_back_to_back_read", b2b_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
